pwm_led_array: RTL and testbench
================================

PWM_LED_ARRAY -- requirements
Module: pwm_led_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8: PWM resolution in bits; period is 2^WIDTH clocks.
REQ-002 SHALL have parameter CHANNELS, default 3: number of independent PWM outputs.
REQ-003 SHALL have parameter STEP, default 1: fade increment per period, WIDTH bits.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port an, input, 1 bit: high inverts all led_o bits for an anode-connected LED; low for a cathode-connected LED.
REQ-007 SHALL have port fade_en, input, 1 bit: high ramps duty toward target; low applies target directly.
REQ-008 SHALL have port cfg_valid, input, 1 bit: cfg_data holds a new set of targets.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the block accepts cfg_data.
REQ-010 SHALL have port cfg_data, input, CHANNELS*WIDTH bits: channel i target in bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port led_o, output, CHANNELS bits: PWM drive, one bit per channel.
REQ-012 SHALL have port sync, output, 1 bit: high while counter == 0.
REQ-013 SHALL have port half, output, 1 bit: counter MSB.
REQ-014 SHALL have port done, output, 1 bit: high when every channel's current duty equals its target.

Function
REQ-015 SHALL keep a WIDTH-bit free-running counter: +1 every clock, wrapping from 2^WIDTH-1 to 0.
REQ-016 SHALL keep a per-channel target register tgt[i] and a current-duty register cur[i].
REQ-017 SHALL drive cfg_ready high whenever rst is high; no back-pressure.
REQ-018 SHALL load all tgt[i] from cfg_data at the edge where cfg_valid and cfg_ready are both high; all channels update together.
REQ-019 SHALL update cur[i] only at the edge where counter == 2^WIDTH-1, so cur is constant over each full period.
REQ-020 At that edge with fade_en low, SHALL set cur[i] = tgt[i].
REQ-021 At that edge with fade_en high:
- if cur[i] < tgt[i], SHALL set cur[i] = cur[i] + min(STEP, tgt[i]-cur[i]);
- if cur[i] > tgt[i], SHALL set cur[i] = cur[i] - min(STEP, cur[i]-tgt[i]);
- SHALL never overshoot tgt[i] or wrap past 0 or 2^WIDTH-1.
REQ-022 If a cfg accept coincides with counter == 2^WIDTH-1, the cur update SHALL use the old tgt; the new tgt takes effect at the next period boundary.
REQ-023 SHALL compute the registered PWM bit p[i] each clock as (cur[i] == 2^WIDTH-1) OR (cur[i] > counter), one clock of latency.
REQ-024 Resulting duty per channel:
- cur = 0 SHALL give constant off;
- cur = 2^WIDTH-1 SHALL give constant on;
- any other value SHALL give exactly cur on-clocks per period.
REQ-025 SHALL drive led_o[i] = p[i] XOR an (combinational); an SHALL take effect with no latency.
REQ-026 SHALL make sync, half and done combinational from registered state; done = AND over i of (cur[i] == tgt[i]).
REQ-027 Toggling fade_en mid-fade SHALL take effect at the next period boundary, with no glitch on led_o inside a period.

Reset
REQ-028 While rst is low, SHALL force counter = 0, all tgt = 0, all cur = 0, all p = 0 and cfg_ready = 0.
REQ-029 During reset, SHALL drive led_o = {CHANNELS{an}} (LEDs off), sync = 1, half = 0 and done = 1.
REQ-030 Reset asserted mid-period or mid-fade SHALL abort immediately; after release, counting SHALL restart from 0 and cfg_ready SHALL rise in the first cycle.

Verification
REQ-031 Use WIDTH=4, CHANNELS=3, STEP=2 for REQ-032 to REQ-036.
REQ-032 Scenario: fade_en=0, an=0, load targets {ch0=0, ch1=5, ch2=15} -> from the period after the next boundary, per 16 clocks: ch0 high 0 clocks, ch1 high 5, ch2 high 16; done=1.
REQ-033 Scenario: fade_en=1, ch1 moves from 0 to target 5 -> cur1 takes 2, 4, 5 on three successive boundaries; done=0 until cur1=5, then done=1.
REQ-034 Scenario: fade_en=1, cur1=15, load target 0 -> cur1 takes 13, 11, ..., 1, 0; no underflow.
REQ-035 Scenario: cfg accept exactly at counter=15 -> the next period uses the old targets; the one after uses the new targets.
REQ-036 Scenario: an=1 with duty 5 -> led_o low for 5 clocks per period; pulse rst low at counter=9 mid-fade -> led_o = 3'b111 immediately, all state zero, sync=1 after release.

Source files
------------

// File: rtl/pwm_led_array.sv
// Multi-channel PWM LED driver: one shared free-running period counter, per-channel
// target/current duty registers with optional step-limited fading at period boundaries.
module pwm_led_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int STEP     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      an,
  input  logic                      fade_en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CHANNELS*WIDTH-1:0] cfg_data,
  output logic [CHANNELS-1:0]       led_o,
  output logic                      sync,
  output logic                      half,
  output logic                      done
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

  logic [WIDTH-1:0]    count_reg;
  logic [CHANNELS-1:0] pwm;
  logic [CHANNELS-1:0] match;
  logic                wrap;
  logic                accept;

  assign wrap      = (count_reg == CNT_MAX);
  assign cfg_ready = rst;
  assign accept    = cfg_valid & cfg_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] tgt_reg;
      logic [WIDTH-1:0] cur_reg;
      logic [WIDTH-1:0] cur_next;
      logic [WIDTH-1:0] up_gap;
      logic [WIDTH-1:0] dn_gap;
      logic             p_reg;

      // Gaps are only used on the side where they are non-negative, so no wrap can occur.
      always_comb begin
        up_gap   = tgt_reg - cur_reg;
        dn_gap   = cur_reg - tgt_reg;
        cur_next = cur_reg;
        if (!fade_en) begin
          cur_next = tgt_reg;
        end else if (cur_reg < tgt_reg) begin
          cur_next = cur_reg + ((up_gap < STEP_W) ? up_gap : STEP_W);
        end else if (cur_reg > tgt_reg) begin
          cur_next = cur_reg - ((dn_gap < STEP_W) ? dn_gap : STEP_W);
        end
      end

      // cur_next is built from the pre-edge tgt_reg, so a load on the wrap edge lands one period later.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tgt_reg <= '0;
          cur_reg <= '0;
          p_reg   <= 1'b0;
        end else begin
          if (accept) begin
            tgt_reg <= cfg_data[gi*WIDTH +: WIDTH];
          end
          if (wrap) begin
            cur_reg <= cur_next;
          end
          p_reg <= (cur_reg == CNT_MAX) || (cur_reg > count_reg);
        end
      end

      assign pwm[gi]   = p_reg;
      assign match[gi] = (cur_reg == tgt_reg);
    end
  endgenerate

  assign led_o = pwm ^ {CHANNELS{an}};
  assign sync  = (count_reg == '0);
  assign half  = count_reg[WIDTH-1];
  assign done  = &match;

endmodule

// File: tb/tb_pwm_led_array.sv
// Directed scenarios plus a randomized run, all checked against a per-cycle reference
// model that tracks counter, targets and duties with plain integer arithmetic.
module tb_pwm_led_array;

  localparam int W  = 4;
  localparam int CH = 3;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          an = 1'b0;
  logic          fade_en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [11:0]   cfg_data = '0;
  logic [2:0]    led_o;
  logic          sync;
  logic          half;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  int         m_cnt;
  int         m_tgt [CH];
  int         m_cur [CH];
  logic [2:0] m_p;

  pwm_led_array #(.WIDTH(W), .CHANNELS(CH), .STEP(ST)) dut (
    .clk(clk), .rst(rst), .an(an), .fade_en(fade_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .led_o(led_o), .sync(sync), .half(half), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_p   = '0;
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = 0;
      m_cur[i] = 0;
    end
  endtask

  task automatic check_outputs();
    logic all_eq;
    all_eq = 1'b1;
    for (int i = 0; i < CH; i++) if (m_cur[i] != m_tgt[i]) all_eq = 1'b0;
    check("led_o", led_o, m_p ^ {3{an}});
    check("sync", sync, m_cnt == 0);
    check("half", half, m_cnt >= 8);
    check("done", done, all_eq);
    check("cfg_ready", cfg_ready, rst);
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++) m_p[i] = (m_cur[i] == 15) || (m_cur[i] > m_cnt);
      if (m_cnt == 15) begin
        for (int i = 0; i < CH; i++) begin
          if (!fade_en)                 m_cur[i] = m_tgt[i];
          else if (m_tgt[i] > m_cur[i]) m_cur[i] = (m_cur[i] + ST > m_tgt[i]) ? m_tgt[i] : m_cur[i] + ST;
          else                          m_cur[i] = (m_cur[i] - ST < m_tgt[i]) ? m_tgt[i] : m_cur[i] - ST;
        end
      end
      if (cfg_valid) for (int i = 0; i < CH; i++) m_tgt[i] = int'(cfg_data[i*4 +: 4]);
      m_cnt = (m_cnt + 1) % 16;
    end
    #1;
    check_outputs();
  endtask

  task automatic load(input logic [11:0] d);
    cfg_data  = d;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    for (int n = 0; n < 40 && m_cnt != target; n++) tick();
  endtask

  // Entered with counter at 0; returns high clocks of led_o per channel over one PWM period.
  task automatic measure(output int h0, output int h1, output int h2);
    h0 = 0; h1 = 0; h2 = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      h0 += int'(led_o[0]);
      h1 += int'(led_o[1]);
      h2 += int'(led_o[2]);
    end
  endtask

  initial begin
    int h0, h1, h2;
    int fade_up [3]   = '{2, 4, 5};
    int done_up [3]   = '{0, 0, 1};
    int fade_dn [9]   = '{13, 11, 9, 7, 5, 3, 1, 0, 0};

    model_reset();
    #1 rst = 1'b0;
    #1;
    check("rst_led", led_o, 3'b000);
    check("rst_sync", sync, 1'b1);
    check("rst_half", half, 1'b0);
    check("rst_done", done, 1'b1);
    check("rst_ready", cfg_ready, 1'b0);
    an = 1'b1;
    #1 check("rst_led_an", led_o, 3'b111);
    an = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1 check("ready_rise", cfg_ready, 1'b1);

    // Static duties with fading off.
    fade_en = 1'b0;
    load({4'd15, 4'd5, 4'd0});
    wait_cnt(0);
    measure(h0, h1, h2);
    check("static_ch0", h0, 0);
    check("static_ch1", h1, 5);
    check("static_ch2", h2, 16);
    check("static_done", done, 1'b1);

    // Fade up 0 -> 5 in steps of 2.
    load({4'd0, 4'd0, 4'd0});
    wait_cnt(0);
    fade_en = 1'b1;
    load({4'd0, 4'd5, 4'd0});
    check("fade_up_done0", done, 1'b0);
    wait_cnt(0);
    for (int k = 0; k < 3; k++) begin
      check("fade_up_done", done, done_up[k]);
      measure(h0, h1, h2);
      check("fade_up_duty", h1, fade_up[k]);
    end

    // Fade down 15 -> 0 without underflow.
    fade_en = 1'b0;
    load({4'd0, 4'd15, 4'd0});
    wait_cnt(0);
    fade_en = 1'b1;
    load({4'd0, 4'd0, 4'd0});
    wait_cnt(0);
    for (int k = 0; k < 9; k++) begin
      measure(h0, h1, h2);
      check("fade_dn_duty", h1, fade_dn[k]);
    end

    // Load coinciding with counter 15 applies one period late.
    fade_en = 1'b0;
    load({4'd0, 4'd3, 4'd0});
    wait_cnt(0);
    wait_cnt(15);
    load({4'd0, 4'd9, 4'd0});
    measure(h0, h1, h2);
    check("late_old_tgt", h1, 3);
    measure(h0, h1, h2);
    check("late_new_tgt", h1, 9);

    // Anode polarity, then asynchronous reset mid-fade.
    an = 1'b1;
    load({4'd5, 4'd5, 4'd5});
    wait_cnt(0);
    measure(h0, h1, h2);
    check("anode_low_clks", 16 - h1, 5);
    fade_en = 1'b1;
    load({4'd0, 4'd15, 4'd0});
    wait_cnt(0);
    wait_cnt(9);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("abort_led", led_o, 3'b111);
    check("abort_sync", sync, 1'b1);
    check("abort_done", done, 1'b1);
    check("abort_ready", cfg_ready, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("release_sync", sync, 1'b1);
    check("release_ready", cfg_ready, 1'b1);
    tick();
    check("restart_half", half, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_data  = 12'($urandom);
        cfg_valid = 1'b1;
      end else begin
        cfg_valid = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) fade_en = ~fade_en;
      if ($urandom_range(0, 15) == 0) an = ~an;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        tick();
        rst = 1'b1;
        #1 check_outputs();
      end
      tick();
    end
    cfg_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
